// File: rtl/heart_rate_meter.sv
// Converts synchronised peak events into inter-beat intervals (ms), averages the last
// N_AVG plausible intervals and derives BPM with a restoring divider; tracks loss of signal.
module heart_rate_meter #(
  parameter int unsigned CLK_HZ     = 40_000_000,
  parameter int unsigned N_AVG      = 4,
  parameter int unsigned MIN_IBI_MS = 300,
  parameter int unsigned MAX_IBI_MS = 2000,
  parameter int unsigned TIMEOUT_MS = 3000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       peak_in,
  output logic [7:0] bpm,
  output logic       bpm_valid,
  output logic       locked,
  output logic       no_signal
);

  localparam int unsigned TICK_DIV = CLK_HZ / 1000;
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW       = $clog2(N_AVG);
  localparam int unsigned FW       = $clog2(N_AVG + 1);

  typedef enum logic [1:0] {IDLE, ARMED, TRACK} state_t;

  state_t st;

  // Peak synchroniser plus edge-detect flop
  logic [2:0] sync;
  logic       peak_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[1:0], peak_in};
  end

  assign peak_evt = sync[1] & ~sync[2];

  // Millisecond prescaler
  logic [PW-1:0] pre;
  logic          tick;

  assign tick = (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  // Interval measurement and averaging state
  logic [11:0]   ibi_ms;
  logic [11:0]   ring [N_AVG];
  logic [AW-1:0] wptr;
  logic [FW-1:0] fill;
  logic [14:0]   sum;

  logic          active, timeout, accept, reject;
  logic [14:0]   sum_next;
  logic [11:0]   avg_next;
  logic          full_after;

  assign active     = (st != IDLE);
  assign timeout    = active && tick && (ibi_ms == 12'(TIMEOUT_MS - 1));
  assign accept     = active && peak_evt && !timeout &&
                      (ibi_ms >= 12'(MIN_IBI_MS)) && (ibi_ms <= 12'(MAX_IBI_MS));
  assign reject     = active && peak_evt && !timeout && (ibi_ms > 12'(MAX_IBI_MS));
  assign sum_next   = sum + 15'(ibi_ms) - 15'(ring[wptr]);
  assign avg_next   = 12'(sum_next >> AW);
  assign full_after = (fill >= FW'(N_AVG - 1));

  // Restoring divider datapath: one quotient bit per cycle
  logic [15:0] dq;
  logic [12:0] drem;
  logic [11:0] dvs;
  logic [4:0]  dcnt;
  logic        dbusy;
  logic [12:0] rem_sh, rem_new;
  logic        ge;
  logic [15:0] q_new;
  logic [7:0]  q_sat;

  always_comb begin
    rem_sh  = {drem[11:0], dq[15]};
    ge      = (rem_sh >= {1'b0, dvs});
    rem_new = ge ? (rem_sh - {1'b0, dvs}) : rem_sh;
    q_new   = {dq[14:0], ge};
    q_sat   = (|dq[15:8]) ? 8'hFF : dq[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      ibi_ms    <= '0;
      wptr      <= '0;
      fill      <= '0;
      sum       <= '0;
      for (int unsigned i = 0; i < N_AVG; i++) ring[i] <= '0;
      dq        <= '0;
      drem      <= '0;
      dvs       <= '0;
      dcnt      <= '0;
      dbusy     <= 1'b0;
      bpm       <= '0;
      bpm_valid <= 1'b0;
      locked    <= 1'b0;
      no_signal <= 1'b1;
    end else begin
      bpm_valid <= 1'b0;

      // Divider runs independently; the FSM below may override it (load or abort).
      if (dbusy) begin
        if (dcnt == 5'd16) begin
          bpm       <= q_sat;
          bpm_valid <= 1'b1;
          locked    <= 1'b1;
          dbusy     <= 1'b0;
        end else begin
          dq   <= q_new;
          drem <= rem_new;
          dcnt <= dcnt + 1'b1;
        end
      end

      case (st)
        IDLE: begin
          ibi_ms <= '0;
          if (peak_evt) st <= ARMED;
        end
        default: begin
          if (timeout) begin
            st        <= IDLE;
            ibi_ms    <= '0;
            wptr      <= '0;
            fill      <= '0;
            sum       <= '0;
            for (int unsigned i = 0; i < N_AVG; i++) ring[i] <= '0;
            dbusy     <= 1'b0;
            bpm       <= '0;
            bpm_valid <= 1'b0;
            locked    <= 1'b0;
            no_signal <= 1'b1;
          end else begin
            if (accept || reject)           ibi_ms <= '0;
            else if (tick && ibi_ms != '1)  ibi_ms <= ibi_ms + 1'b1;

            if (accept) begin
              ring[wptr] <= ibi_ms;
              wptr       <= wptr + 1'b1;
              sum        <= sum_next;
              if (!full_after) fill <= fill + 1'b1;
              else             fill <= FW'(N_AVG);
              st         <= TRACK;
              no_signal  <= 1'b0;
              if (full_after) begin
                dq    <= 16'd60000;
                drem  <= '0;
                dvs   <= avg_next;
                dcnt  <= '0;
                dbusy <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_heart_rate_meter.sv
// Bench for heart_rate_meter at 1 ms per clock: directed beat table, hand-built corner
// sequences (reset, timeout, mid-divide reset) and random beat trains against a beat-level model.
module tb_heart_rate_meter;

  localparam int N_AVG  = 4;
  localparam int MIN_MS = 300;
  localparam int MAX_MS = 2000;
  localparam int TMO_MS = 3000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       peak_in = 1'b0;
  logic [7:0] bpm;
  logic       bpm_valid, locked, no_signal;

  heart_rate_meter #(
    .CLK_HZ(1000), .N_AVG(N_AVG), .MIN_IBI_MS(MIN_MS), .MAX_IBI_MS(MAX_MS), .TIMEOUT_MS(TMO_MS)
  ) dut (
    .clk(clk), .reset(reset), .peak_in(peak_in),
    .bpm(bpm), .bpm_valid(bpm_valid), .locked(locked), .no_signal(no_signal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int npulse = 0;
  int last_pulse_cyc = -1;
  int n_chk = 0;
  int n_pass = 0;
  int last_rise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bpm_valid) begin
      npulse         <= npulse + 1;
      last_pulse_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input string what, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s.%s: actual %0d required %0d", tag, what, act, exp);
  endtask

  // A peak_in rising at cycle c yields peak_evt in cycle c+2; bpm_valid is due 18 cycles later.
  task automatic apply(input int gap, input int hold, input int ep, input int eb,
                       input int el, input int en, input string tag);
    int rise, p0;
    while (cyc < last_rise + gap) @(negedge clk);
    rise = cyc;
    p0 = npulse;
    peak_in = 1'b1;
    repeat (hold) @(negedge clk);
    peak_in = 1'b0;
    while (cyc < rise + 22) @(negedge clk);
    chk(tag, "pulses", npulse - p0, ep);
    if (ep != 0) chk(tag, "pulse_delay", last_pulse_cyc - rise, 20);
    chk(tag, "bpm", int'(bpm), eb);
    chk(tag, "locked", int'(locked), el);
    chk(tag, "no_signal", int'(no_signal), en);
    last_rise = rise;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk(tag, "bpm", int'(bpm), 0);
    chk(tag, "bpm_valid", int'(bpm_valid), 0);
    chk(tag, "locked", int'(locked), 0);
    chk(tag, "no_signal", int'(no_signal), 1);
  endtask

  // Beat-level reference model: works on peak arrival times only.
  bit m_have_ref;
  int m_ref;
  int m_win[$];
  int m_bpm, m_lock, m_ns;

  task automatic model_reset();
    m_have_ref = 1'b0;
    m_win.delete();
    m_bpm  = 0;
    m_lock = 0;
    m_ns   = 1;
  endtask

  task automatic model_beat(input int t, output int pulse);
    int ibi, sum, q;
    pulse = 0;
    if (m_have_ref && (t - m_ref > TMO_MS)) model_reset();
    if (!m_have_ref) begin
      m_have_ref = 1'b1;
      m_ref = t;
    end else begin
      ibi = t - m_ref - 1;
      if (ibi >= MIN_MS && ibi <= MAX_MS) begin
        m_win.push_back(ibi);
        if (m_win.size() > N_AVG) void'(m_win.pop_front());
        m_ref = t;
        m_ns = 0;
        if (m_win.size() == N_AVG) begin
          sum = 0;
          foreach (m_win[k]) sum += m_win[k];
          q = 60000 / (sum / N_AVG);
          m_bpm  = (q > 255) ? 255 : q;
          m_lock = 1;
          pulse  = 1;
        end
      end else if (ibi > MAX_MS) begin
        m_ref = t;
      end
    end
  endtask

  typedef struct {
    int gap;
    int hold;
    int pulse;
    int bpm;
    int lock;
    int ns;
  } vec_t;

  vec_t tbl [19];

  initial begin
    #15_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int rise, p0, r, gap, hold, p;

    tbl[0]  = '{50,   2,  0, 0,  0, 1};
    tbl[1]  = '{750,  2,  0, 0,  0, 0};
    tbl[2]  = '{750,  2,  0, 0,  0, 0};
    tbl[3]  = '{750,  2,  0, 0,  0, 0};
    tbl[4]  = '{750,  2,  1, 80, 1, 0};
    tbl[5]  = '{600,  2,  1, 84, 1, 0};
    tbl[6]  = '{750,  2,  1, 84, 1, 0};
    tbl[7]  = '{750,  2,  1, 84, 1, 0};
    tbl[8]  = '{750,  2,  1, 84, 1, 0};
    tbl[9]  = '{750,  2,  1, 80, 1, 0};
    tbl[10] = '{100,  2,  0, 80, 1, 0};
    tbl[11] = '{650,  2,  1, 80, 1, 0};
    tbl[12] = '{750,  50, 1, 80, 1, 0};
    tbl[13] = '{301,  2,  1, 94, 1, 0};
    tbl[14] = '{300,  2,  0, 94, 1, 0};
    tbl[15] = '{1701, 2,  1, 63, 1, 0};
    tbl[16] = '{2002, 2,  0, 63, 1, 0};
    tbl[17] = '{2500, 2,  0, 63, 1, 0};
    tbl[18] = '{750,  2,  1, 63, 1, 0};

    // Reset values, and a peak pulse during reset must have no effect
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    peak_in = 1'b1;
    repeat (5) @(negedge clk);
    peak_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    last_rise = cyc;
    repeat (10) @(negedge clk);
    check_idle_outputs("post_reset");
    chk("post_reset", "pulses", npulse, 0);

    for (int i = 0; i < 19; i++)
      apply(tbl[i].gap, tbl[i].hold, tbl[i].pulse, tbl[i].bpm, tbl[i].lock, tbl[i].ns,
            $sformatf("tbl%0d", i));

    // Timeout: expires exactly 3000 ticks after the last accepted beat
    p0 = npulse;
    while (cyc < last_rise + 3002) @(negedge clk);
    chk("timeout_before", "no_signal", int'(no_signal), 0);
    chk("timeout_before", "locked", int'(locked), 1);
    chk("timeout_before", "bpm", int'(bpm), 63);
    @(negedge clk);
    check_idle_outputs("timeout_after");
    chk("timeout_after", "pulses", npulse - p0, 0);

    apply(3050, 2, 0, 0, 0, 1, "retrain0");
    for (int i = 1; i < 4; i++) apply(1000, 2, 0, 0, 0, 0, $sformatf("retrain%0d", i));
    apply(1000, 2, 1, 60, 1, 0, "retrain4");

    // Reset in the middle of a division
    while (cyc < last_rise + 1000) @(negedge clk);
    rise = cyc;
    p0 = npulse;
    peak_in = 1'b1;
    repeat (2) @(negedge clk);
    peak_in = 1'b0;
    while (cyc < rise + 12) @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_div_reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    while (cyc < rise + 30) @(negedge clk);
    chk("mid_div_reset", "pulses", npulse - p0, 0);
    check_idle_outputs("mid_div_after");

    last_rise = cyc;
    apply(50, 2, 0, 0, 0, 1, "fresh0");
    for (int i = 1; i < 4; i++) apply(500, 2, 0, 0, 0, 0, $sformatf("fresh%0d", i));
    apply(500, 2, 1, 120, 1, 0, "fresh4");

    // Random beat trains against the model
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    last_rise = cyc;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)       gap = $urandom_range(30, 299);
      else if (r < 7)  gap = $urandom_range(300, 1200);
      else if (r == 7) gap = $urandom_range(1995, 2006);
      else if (r == 8) gap = $urandom_range(2100, 2900);
      else             gap = $urandom_range(3010, 3400);
      if (m_have_ref && (last_rise + gap - m_ref >= 2990) && (last_rise + gap - m_ref <= 3010))
        gap += 25;
      hold = $urandom_range(2, 8);
      model_beat(last_rise + gap, p);
      apply(gap, hold, p, m_bpm, m_lock, m_ns, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
